// File: rtl/parking_pkg.sv
// Shared encodings and sizes for the parking gate scheduler and its core interface.
package parking_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_REJECT = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ISSUE  = ST_ISSUE,
    REJECT = ST_REJECT,
    HOLD   = ST_HOLD
  } state_e;

  localparam int SLOT_COUNT = 4;
  localparam int CAP_W      = 3;
  localparam int LOC_W      = 2;
endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping, as one-hot plus index.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);
  always_comb begin
    int c;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    for (int i = 0; i < N; i++) begin
      c = (int'(ptr) + i) % N;
      if (!any && req[c]) begin
        any      = 1'b1;
        idx      = PW'(c);
        grant[c] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/parking_gate_scheduler.sv
// Serialises entry/exit gate requests onto the one-event-per-cycle parking core,
// exits first, round-robin per class, with a fixed door/full-light dwell after each decision.
module parking_gate_scheduler
  import parking_pkg::*;
#(
  parameter int N_ENTRY     = 2,
  parameter int N_EXIT      = 2,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [N_ENTRY-1:0]      entry_req,
  input  logic [N_EXIT-1:0]       exit_req,
  input  logic [2*N_EXIT-1:0]     exit_loc,
  input  logic [SLOT_COUNT-1:0]   slot_state,
  input  logic [CAP_W-1:0]        capacity,
  output logic                    core_entry_sensor,
  output logic                    core_exit_sensor,
  output logic [LOC_W-1:0]        core_exit_location,
  output logic [N_ENTRY-1:0]      entry_grant,
  output logic [N_EXIT-1:0]       exit_grant,
  output logic [N_ENTRY-1:0]      entry_reject,
  output logic [N_EXIT-1:0]       exit_reject,
  output logic                    door_open,
  output logic                    full_light
);
  localparam int EPW   = (N_ENTRY > 1) ? $clog2(N_ENTRY) : 1;
  localparam int XPW   = (N_EXIT > 1) ? $clog2(N_EXIT) : 1;
  localparam int CNT_W = $clog2(HOLD_CYCLES) + 1;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [EPW-1:0]       entry_ptr_q, entry_ptr_d;
  logic [XPW-1:0]       exit_ptr_q, exit_ptr_d;
  logic                 core_entry_q, core_entry_d;
  logic                 core_exit_q, core_exit_d;
  logic [LOC_W-1:0]     core_loc_q, core_loc_d;
  logic [N_ENTRY-1:0]   entry_grant_q, entry_grant_d;
  logic [N_EXIT-1:0]    exit_grant_q, exit_grant_d;
  logic [N_ENTRY-1:0]   entry_reject_q, entry_reject_d;
  logic [N_EXIT-1:0]    exit_reject_q, exit_reject_d;
  logic                 door_q, door_d;
  logic                 full_q, full_d;

  logic [N_ENTRY-1:0]   en_onehot;
  logic [EPW-1:0]       en_idx;
  logic                 en_any;
  logic [N_EXIT-1:0]    ex_onehot;
  logic [XPW-1:0]       ex_idx;
  logic                 ex_any;
  logic [LOC_W-1:0]     sel_loc;

  rr_pick #(.N(N_ENTRY), .PW(EPW)) u_entry_pick (
    .req(entry_req), .ptr(entry_ptr_q), .grant(en_onehot), .idx(en_idx), .any(en_any)
  );

  rr_pick #(.N(N_EXIT), .PW(XPW)) u_exit_pick (
    .req(exit_req), .ptr(exit_ptr_q), .grant(ex_onehot), .idx(ex_idx), .any(ex_any)
  );

  assign sel_loc = exit_loc[LOC_W*ex_idx +: LOC_W];

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    entry_ptr_d    = entry_ptr_q;
    exit_ptr_d     = exit_ptr_q;
    core_entry_d   = core_entry_q;
    core_exit_d    = core_exit_q;
    core_loc_d     = core_loc_q;
    entry_grant_d  = entry_grant_q;
    exit_grant_d   = exit_grant_q;
    entry_reject_d = entry_reject_q;
    exit_reject_d  = exit_reject_q;
    door_d         = door_q;
    full_d         = full_q;
    if (enable) begin
      case (state_q)
        IDLE: begin
          if (ex_any) begin
            exit_ptr_d = (ex_idx == XPW'(N_EXIT - 1)) ? '0 : ex_idx + 1'b1;
            if (slot_state[sel_loc]) begin
              state_d      = ISSUE;
              core_exit_d  = 1'b1;
              core_loc_d   = sel_loc;
              exit_grant_d = ex_onehot;
              door_d       = 1'b1;
            end else begin
              state_d       = REJECT;
              exit_reject_d = ex_onehot;
              full_d        = 1'b1;
            end
          end else if (en_any) begin
            entry_ptr_d = (en_idx == EPW'(N_ENTRY - 1)) ? '0 : en_idx + 1'b1;
            if (capacity != '0) begin
              state_d       = ISSUE;
              core_entry_d  = 1'b1;
              entry_grant_d = en_onehot;
              door_d        = 1'b1;
            end else begin
              state_d        = REJECT;
              entry_reject_d = en_onehot;
              full_d         = 1'b1;
            end
          end
        end
        ISSUE, REJECT: begin
          state_d        = HOLD;
          cnt_d          = CNT_W'(HOLD_CYCLES - 1);
          core_entry_d   = 1'b0;
          core_exit_d    = 1'b0;
          core_loc_d     = '0;
          entry_grant_d  = '0;
          exit_grant_d   = '0;
          entry_reject_d = '0;
          exit_reject_d  = '0;
        end
        HOLD: begin
          if (cnt_q == '0) begin
            state_d = IDLE;
            door_d  = 1'b0;
            full_d  = 1'b0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      entry_ptr_q    <= '0;
      exit_ptr_q     <= '0;
      core_entry_q   <= 1'b0;
      core_exit_q    <= 1'b0;
      core_loc_q     <= '0;
      entry_grant_q  <= '0;
      exit_grant_q   <= '0;
      entry_reject_q <= '0;
      exit_reject_q  <= '0;
      door_q         <= 1'b0;
      full_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      entry_ptr_q    <= entry_ptr_d;
      exit_ptr_q     <= exit_ptr_d;
      core_entry_q   <= core_entry_d;
      core_exit_q    <= core_exit_d;
      core_loc_q     <= core_loc_d;
      entry_grant_q  <= entry_grant_d;
      exit_grant_q   <= exit_grant_d;
      entry_reject_q <= entry_reject_d;
      exit_reject_q  <= exit_reject_d;
      door_q         <= door_d;
      full_q         <= full_d;
    end
  end

  // Pulses are masked by enable so a frozen ISSUE/REJECT shows again exactly once on resume.
  assign core_entry_sensor  = core_entry_q & enable;
  assign core_exit_sensor   = core_exit_q & enable;
  assign core_exit_location = core_loc_q & {LOC_W{enable}};
  assign entry_grant        = entry_grant_q & {N_ENTRY{enable}};
  assign exit_grant         = exit_grant_q & {N_EXIT{enable}};
  assign entry_reject       = entry_reject_q & {N_ENTRY{enable}};
  assign exit_reject        = exit_reject_q & {N_EXIT{enable}};
  assign door_open          = door_q;
  assign full_light         = full_q;
endmodule
